// File: rtl/xc_malu_divrem_result.sv
// Finalises div/rem core output: sign fix, divide-by-zero and overflow; result valid 2 cycles after capture.
// Holds the result in OUT until res_ready; core_ready is ignored while busy and flush/reset abandon the result.
module xc_malu_divrem_result (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        core_ready,
    input  logic [31:0] core_quot,
    input  logic [31:0] core_rem,
    output logic        core_flush,
    input  logic [31:0] op_rs1,
    input  logic [31:0] op_rs2,
    input  logic        op_signed,
    input  logic        op_rem,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIX  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        capture;

    logic [31:0] quot_q;
    logic [31:0] rem_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic        signed_q;
    logic        rem_sel_q;

    logic        div_zero;
    logic        sign_ovf;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_val;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                capture = core_ready & ~flush;
                if (capture) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = OUT;
            OUT: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // flush abandons the result; a simultaneous handshake still lands in IDLE
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    assign core_flush = flush | reset | capture;
    assign res_valid  = (state == OUT);
    assign busy       = (state != IDLE);

    assign div_zero = (rs2_q == 32'd0);
    assign sign_ovf = signed_q && (rs1_q == 32'h8000_0000) && (rs2_q == 32'hFFFF_FFFF);

    always_comb begin
        quot_fix = quot_q;
        rem_fix  = rem_q;
        if (div_zero) begin
            quot_fix = 32'hFFFF_FFFF;
            rem_fix  = rs1_q;
        end else if (sign_ovf) begin
            quot_fix = 32'h8000_0000;
            rem_fix  = 32'd0;
        end else if (signed_q) begin
            // core works on magnitudes; remainder takes the dividend's sign
            quot_fix = (rs1_q[31] ^ rs2_q[31]) ? (~quot_q + 32'd1) : quot_q;
            rem_fix  = rs1_q[31] ? (~rem_q + 32'd1) : rem_q;
        end
        fix_val = rem_sel_q ? rem_fix : quot_fix;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            quot_q    <= 32'd0;
            rem_q     <= 32'd0;
            rs1_q     <= 32'd0;
            rs2_q     <= 32'd0;
            signed_q  <= 1'b0;
            rem_sel_q <= 1'b0;
            res_data  <= 32'd0;
        end else begin
            if (capture) begin
                quot_q    <= core_quot;
                rem_q     <= core_rem;
                rs1_q     <= op_rs1;
                rs2_q     <= op_rs2;
                signed_q  <= op_signed;
                rem_sel_q <= op_rem;
            end
            if ((state == FIX) && !flush) begin
                res_data <= fix_val;
            end
        end
    end

endmodule
